// File: rtl/mem_write_arbiter.sv
// Data-memory write-port arbiter: CPU stores vs. a buffered host loader.
// Ports: clk, rst (sync, active-low); cpu_we/cpu_addr/cpu_data in, cpu_stall out;
//        host_valid/host_addr/host_data in, host_ready out; mem_we/mem_a/mem_d out
//        (combinational, for a negedge-writing memory); fifo_count out.
// Option: define ARB_STARVE_GUARD_EN to force a starved host write through.
module mem_write_arbiter #(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 32,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cpu_we,
    input  logic [ADDR_W-1:0]             cpu_addr,
    input  logic [DATA_W-1:0]             cpu_data,
    output logic                          cpu_stall,
    input  logic                          host_valid,
    input  logic [ADDR_W-1:0]             host_addr,
    input  logic [DATA_W-1:0]             host_data,
    output logic                          host_ready,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_a,
    output logic [DATA_W-1:0]             mem_d,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_cfg
        $error("mem_write_arbiter: illegal parameter set");
    end

    logic [ADDR_W-1:0] fifo_a [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              cpu_win;

    assign fifo_empty = (count == '0);
    assign fifo_count = count;
    // Registered count only: a same-cycle pop never frees a slot for a push.
    assign host_ready = rst && (count < CNT_W'(FIFO_DEPTH));
    assign push       = host_valid && host_ready;

`ifdef ARB_STARVE_GUARD_EN
    typedef enum logic {
        CPU_PRI,
        HOST_FORCE
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] starve;
    logic [3:0] starve_nxt;

    always_comb begin
        cpu_win    = 1'b0;
        pop        = 1'b0;
        cpu_stall  = 1'b0;
        state_nxt  = CPU_PRI;
        starve_nxt = starve;
        if (rst) begin
            if (state == HOST_FORCE && !fifo_empty) begin
                pop       = 1'b1;
                cpu_stall = cpu_we;
            end else if (cpu_we) begin
                cpu_win = 1'b1;
            end else begin
                pop = !fifo_empty;
            end
            if (pop) begin
                starve_nxt = '0;
            end else if (!fifo_empty) begin
                starve_nxt = starve + 4'd1;
                if (starve_nxt == 4'(STARVE_LIMIT)) begin
                    state_nxt = HOST_FORCE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= CPU_PRI;
            starve <= '0;
        end else begin
            state  <= state_nxt;
            starve <= starve_nxt;
        end
    end
`else
    assign cpu_stall = 1'b0;

    always_comb begin
        cpu_win = 1'b0;
        pop     = 1'b0;
        if (rst) begin
            cpu_win = cpu_we;
            pop     = !cpu_we && !fifo_empty;
        end
    end
`endif

    always_comb begin
        mem_we = cpu_win || pop;
        mem_a  = '0;
        mem_d  = '0;
        if (cpu_win) begin
            mem_a = cpu_addr;
            mem_d = cpu_data;
        end else if (pop) begin
            mem_a = fifo_a[rd_ptr];
            mem_d = fifo_d[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: push is already blocked while rst is low.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_a[wr_ptr] <= host_addr;
            fifo_d[wr_ptr] <= host_data;
        end
    end

endmodule

// File: doc/mem_write_arbiter.md
MEM_WRITE_ARBITER -- requirements
Module: mem_write_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, width of the data-memory word address.
REQ-002 Parameter DATA_W, default 32, width of the memory write data.
REQ-003 Parameter FIFO_DEPTH, default 4, host write buffer depth; SHALL be a power of two in the range 2..16.
REQ-004 Parameter STARVE_LIMIT, default 3, number of consecutive host-denied cycles before the host is forced through; SHALL be in the range 1..15.
REQ-005 clk  in  1  single clock; the block SHALL sample all inputs and update all state on the rising edge.
REQ-006 rst  in  1  reset, synchronous, active-low.
REQ-007 cpu_we  in  1  CPU store request, valid for the current cycle.
REQ-008 cpu_addr  in  ADDR_W  CPU store word address.
REQ-009 cpu_data  in  DATA_W  CPU store data.
REQ-010 cpu_stall  out  1  CPU store not accepted this cycle; the CPU SHALL hold its PC and store.
REQ-011 host_valid  in  1  host loader write offered.
REQ-012 host_addr  in  ADDR_W  host write address.
REQ-013 host_data  in  DATA_W  host write data.
REQ-014 host_ready  out  1  FIFO can accept; a push occurs when host_valid and host_ready are both high.
REQ-015 mem_we  out  1  write enable to the data-memory write port.
REQ-016 mem_a  out  ADDR_W  write address to the data-memory write port.
REQ-017 mem_d  out  DATA_W  write data to the data-memory write port.
REQ-018 fifo_count  out  clog2(FIFO_DEPTH)+1  number of buffered host writes.

Function
REQ-019 mem_we, mem_a, mem_d and cpu_stall SHALL be combinational from registered state and current inputs, so the negedge-writing memory commits the winner within the same cycle.
REQ-020 Grant states: CPU_PRI and HOST_FORCE, held in a registered state machine.
REQ-021 In CPU_PRI: a cpu_we request wins; otherwise a non-empty FIFO wins and its head entry is popped; if neither requests, mem_we SHALL be 0.
REQ-022 In HOST_FORCE: the FIFO head wins and is popped, and cpu_stall SHALL equal cpu_we.
REQ-023 The starve counter SHALL increment each cycle that the FIFO is non-empty and its head is not granted, and SHALL clear on any pop.
REQ-024 When the starve counter reaches STARVE_LIMIT, the state SHALL move to HOST_FORCE for exactly one cycle, then return to CPU_PRI with the counter cleared.
REQ-025 host_ready SHALL be high only when fifo_count < FIFO_DEPTH, evaluated on registered count, so there is no push on full even when a pop occurs in the same cycle.
REQ-026 A push and a pop in the same cycle SHALL leave fifo_count unchanged; FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-027 Host writes SHALL reach memory in push order, without loss or duplication.
REQ-028 When the FIFO is empty, HOST_FORCE SHALL NOT be entered and cpu_stall SHALL be 0.
REQ-029 When mem_we is 0, mem_a and mem_d SHALL be 0.

Reset
REQ-030 rst low at a rising edge SHALL flush the FIFO (fifo_count=0), clear the starve counter, and set state to CPU_PRI; pending host entries are discarded.
REQ-031 While rst is low: host_ready=0, cpu_stall=0, mem_we=0, mem_a=0, mem_d=0.
REQ-032 Reset asserted mid-operation SHALL take priority over any push, pop or state transition in that cycle.

Configuration
REQ-033 Macro ARB_STARVE_GUARD_EN defined: REQ-023 and REQ-024 are active.
REQ-034 Macro ARB_STARVE_GUARD_EN undefined: there is no starve counter and no HOST_FORCE state; CPU has strict priority, and cpu_stall SHALL be constantly 0.

Verification
REQ-035 Idle FIFO, cpu_we=1, cpu_addr=5, cpu_data=0xA5A5A5A5 -> same cycle mem_we=1, mem_a=5, mem_d=0xA5A5A5A5, cpu_stall=0.
REQ-036 Push 4 host writes (addr 0..3, data 0x10..0x13) with cpu_we=0 -> memory writes in order 0..3, fifo_count returns to 0, host_ready never low.
REQ-037 Guard enabled, one host entry buffered, cpu_we held 1 -> 3 CPU writes, then 1 cycle with host write and cpu_stall=1, then CPU resumes.
REQ-038 cpu_we held 1, 4 pushes -> fifo_count=4, host_ready=0; the fifth host_valid is not accepted until a pop occurs.
REQ-039 Push and pop in the same cycle at fifo_count=2 -> fifo_count stays 2 and write order is preserved across pointer wrap.
REQ-040 rst low with fifo_count=3 and state HOST_FORCE -> next cycle fifo_count=0, CPU_PRI, all outputs 0, and no stale host write appears after reset.
